// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and oversampling constants.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_START  = 7;

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running divider producing a one-cycle oversample tick every BAUD_DIV clocks.
module baud_rate_gen #(
  parameter int unsigned BAUD_DIV = 163
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(BAUD_DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CW'(BAUD_DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampling, with input synchroniser,
// start-glitch rejection and a framing-error flag held alongside the received byte.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned N_BITS_DATA = 8,
  parameter int unsigned SB_TICK     = 16,
  parameter int unsigned BAUD_DIV    = 163
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx,
  output logic                   rx_done_tick,
  output logic [N_BITS_DATA-1:0] dout,
  output logic                   frame_err_o
);

  localparam int unsigned NW = (N_BITS_DATA > 1) ? $clog2(N_BITS_DATA) : 1;

  logic                   s_tick;
  logic [1:0]             sync_q;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [3:0]             s_cnt_q, s_cnt_d;
  logic [NW-1:0]          n_cnt_q, n_cnt_d;
  logic [N_BITS_DATA-1:0] shift_q, shift_d;
  logic [N_BITS_DATA-1:0] dout_q, dout_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;

  baud_rate_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clock (clock),
    .reset (reset),
    .tick  (s_tick)
  );

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Start edge is looked for every clock, not just on ticks.
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(MID_START)) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
            s_cnt_d = '0;
            shift_d = {rx_s, shift_q[N_BITS_DATA-1:1]};
            if (n_cnt_q == NW'(N_BITS_DATA - 1)) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(SB_TICK - 1)) begin
            state_d = IDLE;
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV=4 (64 clocks per bit): directed scenarios plus random frames.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 64;

  logic       clock;
  logic       reset;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err_o;

  int unsigned n_vec;
  int unsigned n_err;

  logic [7:0] got_data[$];
  logic       got_err[$];
  logic [7:0] exp_data[$];
  logic       exp_err[$];
  int unsigned dbl_cnt;
  logic        prev_done;

  uart_rx #(.N_BITS_DATA(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err_o  (frame_err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_done_tick === 1'b1) begin
      got_data.push_back(dout);
      got_err.push_back(frame_err_o);
      if (prev_done === 1'b1) dbl_cnt++;
    end
    prev_done = rx_done_tick;
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  // Bad stop bit: held low long enough to cover the mid-bit sample, then released
  // early enough that the re-entered start check sees the line high again.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int unsigned gap);
    @(negedge clock);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    if (stop_ok) begin
      rx = 1'b1;
      idle(BIT_CLKS);
    end else begin
      rx = 1'b0;
      idle(48);
      rx = 1'b1;
      idle(16);
    end
    rx = 1'b1;
    if (gap > 0) idle(gap);
  endtask

  task automatic clear_q();
    got_data.delete();
    got_err.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rx = 1'b1;
    do_reset();
    n_vec++;
    if (dout !== 8'h00 || frame_err_o !== 1'b0 || rx_done_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: dout=%h ferr=%b done=%b, required 00/0/0", dout, frame_err_o, rx_done_tick);
    end
    n_vec++;
    if (dut.state_q !== 2'b00) begin
      n_err++;
      $display("FAIL reset_state: state=%b, required 00", dut.state_q);
    end
  endtask

  task automatic test_valid_frame();
    clear_q();
    send_frame(8'hA5, 1'b1, 32);
    n_vec++;
    if (got_data.size() != 1) begin
      n_err++;
      $display("FAIL a5_pulses: got %0d pulses, required 1", got_data.size());
    end else begin
      n_vec++;
      if (got_data[0] !== 8'hA5 || got_err[0] !== 1'b0) begin
        n_err++;
        $display("FAIL a5_data: dout=%h ferr=%b, required a5/0", got_data[0], got_err[0]);
      end
    end
    n_vec++;
    if (dout !== 8'hA5) begin
      n_err++;
      $display("FAIL a5_held: dout=%h, required a5", dout);
    end
  endtask

  task automatic test_glitch();
    clear_q();
    @(negedge clock);
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(3 * BIT_CLKS);
    n_vec++;
    if (got_data.size() != 0) begin
      n_err++;
      $display("FAIL glitch_pulse: got %0d pulses, required 0", got_data.size());
    end
    n_vec++;
    if (dut.state_q !== 2'b00) begin
      n_err++;
      $display("FAIL glitch_state: state=%b, required 00", dut.state_q);
    end
    n_vec++;
    if (dout !== 8'hA5 || frame_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_hold: dout=%h ferr=%b, required a5/0", dout, frame_err_o);
    end
  endtask

  task automatic test_frame_error();
    clear_q();
    send_frame(8'h3C, 1'b0, 64);
    n_vec++;
    if (got_data.size() != 1) begin
      n_err++;
      $display("FAIL ferr_pulses: got %0d pulses, required 1", got_data.size());
    end else begin
      n_vec++;
      if (got_data[0] !== 8'h3C || got_err[0] !== 1'b1) begin
        n_err++;
        $display("FAIL ferr_data: dout=%h ferr=%b, required 3c/1", got_data[0], got_err[0]);
      end
    end
    n_vec++;
    if (dut.state_q !== 2'b00 || frame_err_o !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_recover: state=%b ferr=%b, required 00/1", dut.state_q, frame_err_o);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    b = 8'hFF;
    clear_q();
    @(negedge clock);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    rx = b[4];
    idle(BIT_CLKS / 2);
    reset = 1'b1;
    idle(2);
    n_vec++;
    if (dout !== 8'h00 || frame_err_o !== 1'b0 || rx_done_tick !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reset: dout=%h ferr=%b done=%b, required 00/0/0", dout, frame_err_o, rx_done_tick);
    end
    reset = 1'b0;
    rx = 1'b1;
    idle(6 * BIT_CLKS);
    n_vec++;
    if (got_data.size() != 0) begin
      n_err++;
      $display("FAIL abort_pulse: got %0d pulses, required 0", got_data.size());
    end
    send_frame(8'h5A, 1'b1, 32);
    n_vec++;
    if (got_data.size() != 1) begin
      n_err++;
      $display("FAIL abort_next_pulses: got %0d pulses, required 1", got_data.size());
    end else begin
      n_vec++;
      if (got_data[0] !== 8'h5A || got_err[0] !== 1'b0) begin
        n_err++;
        $display("FAIL abort_next_data: dout=%h ferr=%b, required 5a/0", got_data[0], got_err[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 32);
    n_vec++;
    if (got_data.size() != 2) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d pulses, required 2", got_data.size());
    end else begin
      n_vec++;
      if (got_data[0] !== 8'h00 || got_data[1] !== 8'hFF || got_err[0] !== 1'b0 || got_err[1] !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_data: got %h/%h ferr %b/%b, required 00/ff 0/0",
                 got_data[0], got_data[1], got_err[0], got_err[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic        ok;
    int unsigned gap;
    clear_q();
    exp_data.delete();
    exp_err.delete();
    for (int f = 0; f < 10; f++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(3, 0) != 0);
      gap = ok ? $urandom_range(20, 0) : $urandom_range(60, 24);
      exp_data.push_back(b);
      exp_err.push_back(~ok);
      send_frame(b, ok, gap);
    end
    idle(48);
    n_vec++;
    if (got_data.size() != exp_data.size()) begin
      n_err++;
      $display("FAIL rand_pulses: got %0d pulses, required %0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        n_vec++;
        if (got_data[i] !== exp_data[i] || got_err[i] !== exp_err[i]) begin
          n_err++;
          $display("FAIL rand_frame%0d: dout=%h ferr=%b, required %h/%b",
                   i, got_data[i], got_err[i], exp_data[i], exp_err[i]);
        end
      end
    end
  endtask

  task automatic test_pulse_width();
    n_vec++;
    if (dbl_cnt != 0) begin
      n_err++;
      $display("FAIL pulse_width: %0d double-wide pulses, required 0", dbl_cnt);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    dbl_cnt   = 0;
    prev_done = 1'b0;
    rx        = 1'b1;
    reset     = 1'b1;
    idle(2);
    test_reset();
    idle(20);
    test_valid_frame();
    test_glitch();
    test_frame_error();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
